// File: rtl/alu_seq_ctrl.sv
// Sequencing front-end for a WIDTH-bit bit-slice ALU array: arithmetic in one pass, shifts as
// repeated 1-bit passes. Define ALU_SEQ_ROT_EN to build ROL/ROR; otherwise those opcodes are illegal.
module alu_seq_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [SHW-1:0]   req_shamt,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_mode,
    output logic             alu_cin,
    output logic             alu_lin,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpShl = 3'b010;
    localparam logic [2:0] OpShr = 3'b011;
    localparam logic [2:0] OpAsr = 3'b100;
`ifdef ALU_SEQ_ROT_EN
    localparam logic [2:0] OpRol = 3'b101;
    localparam logic [2:0] OpRor = 3'b110;
`endif

    typedef enum logic [1:0] {StIdle, StExec, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [SHW-1:0]     cnt_q;
    logic               cout_q, ovf_q, err_q;
    logic               rsp_vld_q, rsp_cout_q, rsp_ovf_q, rsp_zero_q, rsp_err_q;
    logic [WIDTH-1:0]   rsp_data_q;

    logic req_arith, req_legal, op_arith, op_left, b_msb_eff, ovf_calc;

    always_comb begin
        req_arith = (req_op == OpAdd) || (req_op == OpSub);
`ifdef ALU_SEQ_ROT_EN
        req_legal = (req_op != 3'b111);
        op_left   = (op_q == OpShl) || (op_q == OpRol);
`else
        req_legal = (req_op <= OpAsr);
        op_left   = (op_q == OpShl);
`endif
        op_arith  = (op_q == OpAdd) || (op_q == OpSub);
        b_msb_eff = (op_q == OpSub) ? ~b_q[WIDTH-1] : b_q[WIDTH-1];
        ovf_calc  = (a_q[WIDTH-1] == b_msb_eff) && (alu_y[WIDTH-1] != a_q[WIDTH-1]);
    end

    // Array drive decoded from registered state only; idle and illegal ops present all zeros.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_mode = 2'b00;
        alu_cin  = 1'b0;
        alu_lin  = 1'b0;
        if (state_q == StExec && !err_q) begin
            alu_a    = a_q;
            alu_b    = b_q;
            alu_mode = (op_q == OpSub) ? 2'b11 : 2'b10;
            alu_cin  = (op_q == OpSub);
        end else if (state_q == StShift) begin
            alu_b    = b_q;
            alu_mode = op_left ? 2'b01 : 2'b00;
`ifdef ALU_SEQ_ROT_EN
            alu_cin  = (op_q == OpRol) && b_q[WIDTH-1];
            alu_lin  = ((op_q == OpAsr) && b_q[WIDTH-1]) || ((op_q == OpRor) && b_q[0]);
`else
            alu_lin  = (op_q == OpAsr) && b_q[WIDTH-1];
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_vld) begin
                    if (!req_legal || req_arith || req_shamt == '0) state_d = StExec;
                    else                                            state_d = StShift;
                end
            end
            StExec:  state_d = StDone;
            StShift: if (cnt_q == SHW'(1)) state_d = StDone;
            StDone:  if (rsp_vld_q && rsp_rdy) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_cout_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (req_vld) begin
                        op_q   <= req_op;
                        a_q    <= req_arith ? req_a : '0;
                        b_q    <= req_b;
                        cnt_q  <= req_shamt;
                        err_q  <= !req_legal;
                        cout_q <= 1'b0;
                        ovf_q  <= 1'b0;
                    end
                end
                StExec: begin
                    b_q    <= err_q ? '0 : alu_y;
                    cout_q <= !err_q && op_arith && alu_cout;
                    ovf_q  <= !err_q && op_arith && ovf_calc;
                end
                StShift: begin
                    b_q    <= alu_y;
                    cnt_q  <= cnt_q - SHW'(1);
                    cout_q <= op_left ? b_q[WIDTH-1] : b_q[0];
                end
                StDone: begin
                    // Response registers load one cycle into DONE and hold until handshake.
                    if (!rsp_vld_q) begin
                        rsp_vld_q  <= 1'b1;
                        rsp_data_q <= b_q;
                        rsp_cout_q <= cout_q;
                        rsp_ovf_q  <= ovf_q;
                        rsp_zero_q <= (b_q == '0);
                        rsp_err_q  <= err_q;
                    end else if (rsp_rdy) begin
                        rsp_vld_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_rdy  = (state_q == StIdle);
    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;
    assign rsp_cout = rsp_cout_q;
    assign rsp_ovf  = rsp_ovf_q;
    assign rsp_zero = rsp_zero_q;
    assign rsp_err  = rsp_err_q;

endmodule
